// File: rtl/sp_mul_pkg.sv
// Shared constants and width helpers for the pipelined mixed-sign multiplier.
package sp_mul_pkg;
  localparam int MAX_STAGE = 8;

  function automatic int fpw(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  // Signed output range bounds for a result of width w.
  function automatic longint sat_hi(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/sp_mul_pipe_reg.sv
// One ce-gated pipeline stage: valid always advances with ce, data loads only on a valid sample.
module sp_mul_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] q_o
);
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (ce) begin
      vld_d = vld_i;
      if (vld_i) data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = data_q;
endmodule

// File: rtl/sp_mul_pipe_rs.sv
// Pipelined mixed-sign multiplier with ce stalls, in-band valid, and round/shift/saturate output.
module sp_mul_pipe_rs
  import sp_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 23,
  parameter int A_SIGNED   = 0,
  parameter int B_SIGNED   = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag
);
  localparam int FPW = fpw(din0_WIDTH, din1_WIDTH);
  localparam int RW  = FPW + 1;
  localparam int CW  = ((RW > dout_WIDTH) ? RW : dout_WIDTH) + 1;
  localparam int NP  = (NUM_STAGE >= 3) ? NUM_STAGE - 2 : NUM_STAGE - 1;
  localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [CW-1:0] LIM_HI = CW'(sat_hi(dout_WIDTH));
  localparam logic signed [CW-1:0] LIM_LO = CW'(sat_lo(dout_WIDTH));
  localparam logic signed [RW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << SH1) : RW'(0);

  if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
    $error("sp_mul_pipe_rs: NUM_STAGE out of range");
  end

  logic [din0_WIDTH-1:0] a_s;
  logic [din1_WIDTH-1:0] b_s;
  logic                  v_s;

  if (NUM_STAGE >= 3) begin : g_in
    logic [din0_WIDTH+din1_WIDTH-1:0] in_q;
    sp_mul_pipe_reg #(.WIDTH(din0_WIDTH + din1_WIDTH)) u_in (
      .clk(clk), .rst_n(reset), .ce(ce), .vld_i(in_vld),
      .d_i({din1, din0}), .vld_o(v_s), .q_o(in_q)
    );
    assign {b_s, a_s} = in_q;
  end else begin : g_no_in
    assign a_s = din0;
    assign b_s = din1;
    assign v_s = in_vld;
  end

  // Operands widened straight to FPW; the exact product always fits in FPW signed bits.
  logic signed [FPW-1:0] a_x, b_x;
  always_comb begin
    if (A_SIGNED != 0) a_x = FPW'($signed(a_s));
    else               a_x = FPW'($unsigned(a_s));
    if (B_SIGNED != 0) b_x = FPW'($signed(b_s));
    else               b_x = FPW'($unsigned(b_s));
  end

  logic signed [FPW-1:0] p_c [NP+1];
  logic                  p_v [NP+1];
  assign p_c[0] = a_x * b_x;
  assign p_v[0] = v_s;

  for (genvar i = 0; i < NP; i++) begin : g_prod
    sp_mul_pipe_reg #(.WIDTH(FPW)) u_p (
      .clk(clk), .rst_n(reset), .ce(ce), .vld_i(p_v[i]),
      .d_i(p_c[i]), .vld_o(p_v[i+1]), .q_o(p_c[i+1])
    );
  end

  logic signed [RW-1:0]   r_add, r_sh;
  logic signed [CW-1:0]   r_x;
  logic                   hi_ovf, lo_ovf;
  logic [dout_WIDTH:0]    res;
  always_comb begin
    r_add  = RW'(p_c[NP]) + RND;
    r_sh   = r_add >>> SHIFT;
    r_x    = CW'(r_sh);
    hi_ovf = (r_x > LIM_HI);
    lo_ovf = (r_x < LIM_LO);
    res    = {hi_ovf | lo_ovf, r_x[dout_WIDTH-1:0]};
    if (SAT != 0 && hi_ovf) res[dout_WIDTH-1:0] = LIM_HI[dout_WIDTH-1:0];
    if (SAT != 0 && lo_ovf) res[dout_WIDTH-1:0] = LIM_LO[dout_WIDTH-1:0];
  end

  logic [dout_WIDTH:0] out_q;
  sp_mul_pipe_reg #(.WIDTH(dout_WIDTH + 1)) u_out (
    .clk(clk), .rst_n(reset), .ce(ce), .vld_i(p_v[NP]),
    .d_i(res), .vld_o(out_vld), .q_o(out_q)
  );

  assign dout     = out_q[dout_WIDTH-1:0];
  assign sat_flag = out_q[dout_WIDTH];
endmodule
